// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD_CTRL command front end.
//   CMD_W            : opcode width presented to LCD_CTRL
//   OP_WRITE..OP_MIRY: LCD_CTRL opcodes
//   state_t          : dispatch FSM state encoding
package lcd_ctrl_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] OP_WRITE = 3'd0;
  localparam logic [CMD_W-1:0] OP_SHU   = 3'd1;
  localparam logic [CMD_W-1:0] OP_SHD   = 3'd2;
  localparam logic [CMD_W-1:0] OP_SHL   = 3'd3;
  localparam logic [CMD_W-1:0] OP_SHR   = 3'd4;
  localparam logic [CMD_W-1:0] OP_AVG   = 3'd5;
  localparam logic [CMD_W-1:0] OP_MIRX  = 3'd6;
  localparam logic [CMD_W-1:0] OP_MIRY  = 3'd7;

  typedef enum logic [2:0] {
    ST_WAIT_RDY,
    ST_ISSUE,
    ST_GAP,
    ST_WAIT_DONE,
    ST_FINISH,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/lcd_cmd_scheduler_cmd_fifo.sv
// cmd_fifo: small synchronous FIFO holding host opcodes.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata: write strobe and data (caller never pushes when full)
//   pop, rdata : read strobe and head-of-queue data (caller never pops when empty)
//   full, empty, level: occupancy status
// Pointers carry one extra MSB so full and empty are distinguishable when the
// index bits are equal.
module cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 3,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers already
  // discards the contents and keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// lcd_cmd_scheduler: buffers host opcodes and dispatches them one at a time to
// LCD_CTRL over its busy/cmd_valid handshake, follows the final WRITE through
// to done, and raises a sticky error if the controller hangs.
//   clk, reset            : clock, synchronous active-high reset
//   host_cmd/valid/ready  : host push interface (push on valid && ready)
//   cmd, cmd_valid        : registered opcode and one-cycle dispatch strobe
//   busy, done            : LCD_CTRL status inputs
//   frame_done            : sticky, done seen after WRITE was dispatched
//   timeout_err           : sticky, watchdog expired
//   issued_cnt            : saturating count of dispatched commands
//   fifo_level            : current FIFO occupancy
module lcd_cmd_scheduler
  import lcd_ctrl_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  parameter  int TIMEOUT    = 1024,
  parameter  int CNT_W      = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] host_cmd,
  input  logic             host_valid,
  output logic             host_ready,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  input  logic             busy,
  input  logic             done,
  output logic             frame_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic             closed_q;
  logic [WD_W-1:0]  wd_q;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_valid_q;
  logic             frame_done_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] issued_q;

  logic             push, pop, stall, wd_expired;
  logic             fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_head;

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (host_cmd),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Once WRITE is queued the frame is closed; terminal states accept nothing.
  assign host_ready = !fifo_full && !closed_q && (state_q != ST_ERROR) &&
                      (state_q != ST_FINISH) && !reset;
  assign push       = host_valid && host_ready;
  assign wd_expired = (wd_q == WD_W'(TIMEOUT));

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      ST_WAIT_RDY: begin
        stall = busy;
        if (wd_expired) begin
          state_d = ST_ERROR;
        end else if (!fifo_empty && !busy) begin
          state_d = ST_ISSUE;
          pop     = 1'b1;
        end
      end
      ST_ISSUE:     state_d = (cmd_q == OP_WRITE) ? ST_WAIT_DONE : ST_GAP;
      // One dead cycle so LCD_CTRL can raise busy before the next sample.
      ST_GAP:       state_d = ST_WAIT_RDY;
      ST_WAIT_DONE: begin
        stall = !done;
        if (wd_expired)  state_d = ST_ERROR;
        else if (done)   state_d = ST_FINISH;
      end
      ST_FINISH:    state_d = ST_FINISH;
      ST_ERROR:     state_d = ST_ERROR;
      default:      state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WAIT_RDY;
      closed_q      <= 1'b0;
      wd_q          <= '0;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      issued_q      <= '0;
    end else begin
      state_q     <= state_d;
      // Strobe is high exactly while the FSM sits in ISSUE.
      cmd_valid_q <= (state_d == ST_ISSUE);
      wd_q        <= stall ? wd_q + WD_W'(1) : '0;
      if (pop) cmd_q <= fifo_head;
      if (push && host_cmd == OP_WRITE) closed_q <= 1'b1;
      if (state_q == ST_ISSUE && issued_q != '1) issued_q <= issued_q + CNT_W'(1);
      if (state_q == ST_WAIT_DONE && state_d == ST_FINISH) frame_done_q <= 1'b1;
      if (state_d == ST_ERROR) timeout_err_q <= 1'b1;
    end
  end

  assign cmd         = cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign issued_cnt  = issued_q;

endmodule
